// File: rtl/rr_arb8_pkg.sv
// Shared definitions for the eight-way round-robin arbiter.
//   arb_state_e : FSM encoding (IDLE = 1'b0, BUSY = 1'b1)
//   N_REQ       : number of requesters
//   IDX_W       : width of a requester index
package rr_arb8_pkg;

   localparam int N_REQ = 8;
   localparam int IDX_W = 3;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } arb_state_e;

endpackage

// File: rtl/rr_arb8_if.sv
// Handshake bundle between the requester bank and the arbiter.
//   req     : level request vector, bit i = requester i
//   done    : current owner finished
//   gnt     : one-hot grant, zero when nothing is granted
//   gnt_idx : binary index of the owner, holds its last value when idle
//   gnt_vld : a grant is held
//   timeout : one-cycle pulse on a forced release
// master = requester side, slave = arbiter side.
interface rr_arb8_if;
   import rr_arb8_pkg::*;

   logic [N_REQ-1:0] req;
   logic             done;
   logic [N_REQ-1:0] gnt;
   logic [IDX_W-1:0] gnt_idx;
   logic             gnt_vld;
   logic             timeout;

   modport master (
      output req, done,
      input  gnt, gnt_idx, gnt_vld, timeout
   );

   modport slave (
      input  req, done,
      output gnt, gnt_idx, gnt_vld, timeout
   );

endinterface

// File: rtl/rr_arb8_grant_dec.sv
// Enabled 3-to-8 decoder that turns the registered owner index into the
// one-hot grant vector.
//   en : decoder enable (grant valid)
//   a  : binary index
//   d  : one-hot output, all zeros when en = 0
module grant_dec
   import rr_arb8_pkg::*;
(
   input  logic             en,
   input  logic [IDX_W-1:0] a,
   output logic [N_REQ-1:0] d
);

   always_comb begin
      d = '0;
      if (en) begin
         d[a] = 1'b1;
      end
   end

endmodule

// File: rtl/rr_arb8.sv
// Round-robin arbiter sharing one resource among eight requesters.
// A grant is held until the owner raises done, drops its request, or the
// hold counter reaches MAX_HOLD-1 (forced release, flagged on timeout).
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   arb_if : slave side of rr_arb8_if (req/done in, gnt/gnt_idx/gnt_vld/timeout out)
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no grant held; pick a winner from req starting at ptr
// BUSY    | grant held; count hold cycles and watch for release
module rr_arb8
   import rr_arb8_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   rr_arb8_if.slave    arb_if
);

   localparam int               CNT_W    = $clog2(MAX_HOLD);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

   arb_state_e       state_q;
   logic [IDX_W-1:0] ptr_q;
   logic [IDX_W-1:0] gnt_idx_q;
   logic             gnt_vld_q;
   logic             timeout_q;
   logic [CNT_W-1:0] cnt_q;

   logic             rel_normal;
   logic             at_limit;
   logic [N_REQ-1:0] gnt_w;

   // First set bit of r scanning p, p+1, ... with 3-bit wrap.
   function automatic logic [IDX_W-1:0] rr_pick(
      input logic [N_REQ-1:0] r,
      input logic [IDX_W-1:0] p
   );
      logic [IDX_W-1:0] idx;
      logic [IDX_W-1:0] cand;
      logic             found;
      idx   = '0;
      found = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         cand = p + IDX_W'(i);
         if (!found && r[cand]) begin
            idx   = cand;
            found = 1'b1;
         end
      end
      return idx;
   endfunction

   assign rel_normal = arb_if.done | ~arb_if.req[gnt_idx_q];
   assign at_limit   = (cnt_q == CNT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         ptr_q     <= '0;
         gnt_idx_q <= '0;
         gnt_vld_q <= 1'b0;
         timeout_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         timeout_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (|arb_if.req) begin
                  gnt_idx_q <= rr_pick(arb_if.req, ptr_q);
                  gnt_vld_q <= 1'b1;
                  cnt_q     <= '0;
                  state_q   <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               cnt_q <= cnt_q + CNT_W'(1);
               if (rel_normal || at_limit) begin
                  gnt_vld_q <= 1'b0;
                  state_q   <= ST_IDLE;
                  ptr_q     <= gnt_idx_q + IDX_W'(1);
                  // A coincident done or dropped request wins over the limit.
                  timeout_q <= ~rel_normal;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   grant_dec u_grant_dec (
      .en (gnt_vld_q),
      .a  (gnt_idx_q),
      .d  (gnt_w)
   );

   assign arb_if.gnt     = gnt_w;
   assign arb_if.gnt_idx = gnt_idx_q;
   assign arb_if.gnt_vld = gnt_vld_q;
   assign arb_if.timeout = timeout_q;

endmodule

// File: tb/tb_rr_arb8.sv
// Directed bench for rr_arb8 with MAX_HOLD = 4. Inputs change and outputs
// are sampled 1 time unit after each rising edge.
module tb_rr_arb8;

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_fail;

   rr_arb8_if arb_if();

   rr_arb8 #(.MAX_HOLD(4)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .arb_if (arb_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] exp_gnt;
      n_chk  = 0;
      n_fail = 0;

      // Reset held with all requests up
      rst_n       = 1'b0;
      arb_if.req  = 8'hFF;
      arb_if.done = 1'b0;
      tick();
      tick();
      chk("rst_gnt",     arb_if.gnt,     8'h00);
      chk("rst_gnt_vld", arb_if.gnt_vld, 1'b0);
      chk("rst_gnt_idx", arb_if.gnt_idx, 3'd0);
      chk("rst_timeout", arb_if.timeout, 1'b0);
      rst_n      = 1'b1;
      arb_if.req = 8'h00;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("idle_no_gnt", arb_if.gnt_vld, 1'b0);
      end

      // Rotation with all requesters active, done one cycle after each grant
      arb_if.req = 8'hFF;
      for (int k = 0; k < 9; k++) begin
         exp_gnt = 8'h01 << (k % 8);
         tick();
         chk("rot_gnt", arb_if.gnt, exp_gnt);
         chk("rot_idx", arb_if.gnt_idx, k % 8);
         arb_if.done = 1'b1;
         tick();
         arb_if.done = 1'b0;
         chk("rot_gap", arb_if.gnt, 8'h00);
         chk("rot_gap_to", arb_if.timeout, 1'b0);
      end

      // Sparse wrap: grant 5, then ptr=6 with req 0 and 5 pending
      arb_if.req = 8'h20;
      tick();
      chk("wrap_g5", arb_if.gnt, 8'h20);
      arb_if.req  = 8'b0010_0001;
      arb_if.done = 1'b1;
      tick();
      arb_if.done = 1'b0;
      chk("wrap_rel", arb_if.gnt, 8'h00);
      tick();
      chk("wrap_gnt", arb_if.gnt, 8'h01);
      chk("wrap_idx", arb_if.gnt_idx, 3'd0);
      arb_if.done = 1'b1;
      tick();
      arb_if.done = 1'b0;
      chk("wrap_rel2", arb_if.gnt, 8'h00);

      // Forced release after 4 cycles of hold
      arb_if.req = 8'h08;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("to_hold", arb_if.gnt, 8'h08);
         chk("to_nopulse", arb_if.timeout, 1'b0);
      end
      tick();
      chk("to_fall", arb_if.gnt, 8'h00);
      chk("to_pulse", arb_if.timeout, 1'b1);
      chk("to_vld", arb_if.gnt_vld, 1'b0);
      tick();
      chk("to_regnt", arb_if.gnt, 8'h08);
      chk("to_pulse_end", arb_if.timeout, 1'b0);

      // done coinciding with the hold limit is a normal release
      tick();
      tick();
      tick();
      chk("sim_last", arb_if.gnt, 8'h08);
      arb_if.done = 1'b1;
      tick();
      arb_if.done = 1'b0;
      chk("sim_rel", arb_if.gnt, 8'h00);
      chk("sim_no_to", arb_if.timeout, 1'b0);

      // Dropping the owner's request mid-grant releases on the next edge
      tick();
      chk("drop_gnt", arb_if.gnt, 8'h08);
      tick();
      chk("drop_hold", arb_if.gnt, 8'h08);
      arb_if.req = 8'h00;
      tick();
      chk("drop_rel", arb_if.gnt, 8'h00);
      chk("drop_no_to", arb_if.timeout, 1'b0);
      tick();
      chk("drop_idle", arb_if.gnt_vld, 1'b0);

      // Async reset while requester 4 owns the grant
      arb_if.req = 8'h10;
      tick();
      chk("ar_gnt", arb_if.gnt, 8'h10);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_gnt0", arb_if.gnt, 8'h00);
      chk("ar_vld0", arb_if.gnt_vld, 1'b0);
      chk("ar_idx0", arb_if.gnt_idx, 3'd0);
      chk("ar_to0", arb_if.timeout, 1'b0);
      tick();
      rst_n      = 1'b1;
      arb_if.req = 8'h11;
      tick();
      chk("ar_ptr0", arb_if.gnt, 8'h01);
      chk("ar_to", arb_if.timeout, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
